sha256_block_ctrl: RTL and testbench

Sequencing controller for one SHA-256 hash core. Accepts 512-bit message blocks via a valid/ready handshake and pulses the message scheduler's load input. Then steps the compression datapath through the rounds, issuing the round index used for Wt/Kt selection, the working-variable load and the feed-forward strobe. It holds the digest-valid flag until the consumer accepts it. It owns no data: it drives control only, and sits between the block source and the scheduler/compression datapath.

---
 rtl/sha256_block_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sha256_block_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_ctrl.sv
// ----------------------------------------------------------------------------
// sha256_block_ctrl
//
// Sequencing controller for one SHA-256 hash core. Accepts a 512-bit block
// via a valid/ready handshake (the data itself stays on the datapath bus).
// It then loads the message scheduler and working variables, steps the
// compression rounds, and issues the feed-forward strobe. After the last
// block of a message it holds digest-valid until the consumer takes it.
// This module owns no data; it drives control only.
//
// Parameters:
//   ROUNDS  compression rounds per block (>= 2)
//   CNT_W   round counter width, 2**CNT_W >= ROUNDS
//
// Ports:
//   clk_i         clock
//   reset_i       asynchronous active-high reset
//   v_i           block valid
//   first_i       block is first of a message (sampled on acceptance)
//   last_i        block is last of a message (sampled on acceptance)
//   ready_o       controller can accept a block
//   sched_load_o  one-cycle pulse, message scheduler latches the block
//   work_load_o   working vars a..h <- H (or IV with init_hash_o)
//   init_hash_o   with work_load_o: H <- IV and a..h <- IV
//   round_en_o    compression round advances, Wt valid
//   round_o       current round index t (0 outside the ROUND state)
//   ff_o          feed-forward strobe, H <- H + a..h
//   v_o           digest in H is final
//   yumi_i        consumer takes the digest
//   busy_o        controller is not idle
//   err_o         one-cycle pulse: non-first block with no message open
// ----------------------------------------------------------------------------
module sha256_block_ctrl #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             v_i,
  input  logic             first_i,
  input  logic             last_i,
  output logic             ready_o,
  output logic             sched_load_o,
  output logic             work_load_o,
  output logic             init_hash_o,
  output logic             round_en_o,
  output logic [CNT_W-1:0] round_o,
  output logic             ff_o,
  output logic             v_o,
  input  logic             yumi_i,
  output logic             busy_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FF,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_first, w_first_next;
  logic             r_last, w_last_next;
  logic             r_msg_active, w_msg_active_next;

  logic             w_ready;
  logic             w_sched_load;
  logic             w_work_load;
  logic             w_init_hash;
  logic             w_round_en;
  logic [CNT_W-1:0] w_round;
  logic             w_ff;
  logic             w_v;
  logic             w_err;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_msg_active <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_first      <= w_first_next;
      r_last       <= w_last_next;
      r_msg_active <= w_msg_active_next;
    end
  end

  // Strobes decode from r_state only; v_i/yumi_i affect next state only.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_first_next      = r_first;
    w_last_next       = r_last;
    w_msg_active_next = r_msg_active;
    w_ready           = 1'b0;
    w_sched_load      = 1'b0;
    w_work_load       = 1'b0;
    w_init_hash       = 1'b0;
    w_round_en        = 1'b0;
    w_round           = '0;
    w_ff              = 1'b0;
    w_v               = 1'b0;
    w_err             = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (v_i) begin
          w_first_next = first_i;
          w_last_next  = last_i;
          w_state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        w_sched_load = 1'b1;
        w_work_load  = 1'b1;
        // A non-first block with no open message is still hashed from IV,
        // but flagged. A first block during an open message restarts it.
        w_init_hash       = r_first | ~r_msg_active;
        w_err             = ~r_first & ~r_msg_active;
        w_msg_active_next = 1'b1;
        w_cnt_next        = '0;
        w_state_next      = S_ROUND;
      end

      S_ROUND: begin
        w_round_en = 1'b1;
        w_round    = r_cnt;
        if (r_cnt == LAST_RND) begin
          w_cnt_next   = '0;
          w_state_next = S_FF;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_FF: begin
        w_ff = 1'b1;
        if (r_last) begin
          w_msg_active_next = 1'b0;
          w_state_next      = S_DONE;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      S_DONE: begin
        w_v = 1'b1;
        if (yumi_i) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ready is withheld while reset is held, even though the state reads IDLE.
  assign ready_o      = w_ready & ~reset_i;
  assign sched_load_o = w_sched_load;
  assign work_load_o  = w_work_load;
  assign init_hash_o  = w_init_hash;
  assign round_en_o   = w_round_en;
  assign round_o      = w_round;
  assign ff_o         = w_ff;
  assign v_o          = w_v;
  assign busy_o       = (r_state != S_IDLE);
  assign err_o        = w_err;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sha256_block_ctrl
//
// Self-checking bench for sha256_block_ctrl. Each accepted block pushes its
// expected LOAD-cycle strobes (init_hash, err) to a queue; a monitor pops and
// compares them whenever sched_load_o fires. Last blocks push a digest token
// that is popped on the v_o/yumi_i handshake. Round sequencing, back-pressure
// and mid-round reset are checked directly by the stimulus process.
// ----------------------------------------------------------------------------
module tb_sha256_block_ctrl;

  localparam int ROUNDS = 64;
  localparam int CNT_W  = 6;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             v_i;
  logic             first_i;
  logic             last_i;
  logic             ready_o;
  logic             sched_load_o;
  logic             work_load_o;
  logic             init_hash_o;
  logic             round_en_o;
  logic [CNT_W-1:0] round_o;
  logic             ff_o;
  logic             v_o;
  logic             yumi_i;
  logic             busy_o;
  logic             err_o;

  sha256_block_ctrl #(
    .ROUNDS (ROUNDS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .first_i      (first_i),
    .last_i       (last_i),
    .ready_o      (ready_o),
    .sched_load_o (sched_load_o),
    .work_load_o  (work_load_o),
    .init_hash_o  (init_hash_o),
    .round_en_o   (round_en_o),
    .round_o      (round_o),
    .ff_o         (ff_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic init_hash;
    logic err;
  } load_exp_t;

  load_exp_t load_q[$];
  int        digest_q[$];

  int total_cnt = 0;
  int bad_cnt   = 0;
  int ff_count  = 0;
  int done_count = 0;
  logic tb_msg_open = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk_i) begin
    load_exp_t e;
    if (sched_load_o) begin
      check_val("load_pending", load_q.size() > 0, 1);
      if (load_q.size() > 0) begin
        e = load_q.pop_front();
        check_val("init_hash", init_hash_o, e.init_hash);
        check_val("err_at_load", err_o, e.err);
        check_val("work_load", work_load_o, 1);
        $display("load: init_hash=%0b err=%0b", init_hash_o, err_o);
      end
    end else begin
      check_val("err_quiet", err_o, 0);
    end
    if (ff_o) ff_count++;
    if (v_o && yumi_i) begin
      done_count++;
      check_val("digest_pending", digest_q.size() > 0, 1);
      if (digest_q.size() > 0) void'(digest_q.pop_front());
      $display("digest taken");
    end
  end

  // Offer a block at a falling edge once ready_o is seen; returns at the
  // falling edge of the LOAD cycle with v_i dropped.
  task automatic accept_block(input logic f, input logic l);
    int n = 0;
    load_exp_t e;
    while (!ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check_val("accept_ready", ready_o, 1);
    if (!ready_o) return;
    v_i = 1'b1;
    first_i = f;
    last_i = l;
    e.init_hash = f | ~tb_msg_open;
    e.err = ~f & ~tb_msg_open;
    load_q.push_back(e);
    if (l) digest_q.push_back(1);
    tb_msg_open = ~l;
    $display("accept: first=%0b last=%0b", f, l);
    @(negedge clk_i);
    v_i = 1'b0;
    check_val("load_cycle", sched_load_o, 1);
    check_val("busy_load", busy_o, 1);
  endtask

  // From the LOAD negedge: ROUNDS round cycles, then the FF cycle.
  task automatic check_rounds();
    for (int t = 0; t < ROUNDS; t++) begin
      @(negedge clk_i);
      check_val("round_en", round_en_o, 1);
      check_val("round_idx", round_o, t);
    end
    @(negedge clk_i);
    check_val("ff_strobe", ff_o, 1);
    check_val("ff_round0", round_o, 0);
  endtask

  // From the FF negedge with yumi_i high: one DONE cycle, then IDLE.
  task automatic check_done_fast();
    @(negedge clk_i);
    check_val("done_v", v_o, 1);
    check_val("done_ready", ready_o, 0);
    @(negedge clk_i);
    check_val("after_done_ready", ready_o, 1);
    check_val("after_done_v", v_o, 0);
  endtask

  initial begin
    int ff0;
    int done0;
    int n;
    reset_i = 1'b1;
    v_i = 1'b0;
    first_i = 1'b0;
    last_i = 1'b0;
    yumi_i = 1'b1;

    // Reset state
    @(negedge clk_i);
    check_val("rst_ready", ready_o, 0);
    check_val("rst_busy", busy_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_val("idle_ready", ready_o, 1);
    check_val("idle_round", round_o, 0);
    check_val("idle_v", v_o, 0);
    check_val("idle_ff", ff_o, 0);

    // Single-block message
    ff0 = ff_count; done0 = done_count;
    accept_block(1'b1, 1'b1);
    check_rounds();
    check_done_fast();
    check_val("single_ff_cnt", ff_count - ff0, 1);
    check_val("single_done_cnt", done_count - done0, 1);

    // Two-block message, second offered as soon as ready returns
    ff0 = ff_count; done0 = done_count;
    accept_block(1'b1, 1'b0);
    check_rounds();
    @(negedge clk_i);
    check_val("mid_msg_ready", ready_o, 1);
    check_val("mid_msg_v", v_o, 0);
    accept_block(1'b0, 1'b1);
    check_rounds();
    check_done_fast();
    check_val("two_ff_cnt", ff_count - ff0, 2);
    check_val("two_done_cnt", done_count - done0, 1);

    // Back-pressure in DONE
    yumi_i = 1'b0;
    accept_block(1'b1, 1'b1);
    check_rounds();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check_val("bp_v", v_o, 1);
      check_val("bp_ready", ready_o, 0);
    end
    yumi_i = 1'b1;
    @(negedge clk_i);
    check_val("bp_release_ready", ready_o, 1);
    check_val("bp_release_v", v_o, 0);

    // v_i held during rounds with a different first_i is ignored
    ff0 = ff_count; done0 = done_count;
    accept_block(1'b1, 1'b1);
    v_i = 1'b1;
    first_i = 1'b0;
    last_i = 1'b0;
    check_rounds();
    v_i = 1'b0;
    check_done_fast();
    check_val("hold_ff_cnt", ff_count - ff0, 1);
    check_val("hold_done_cnt", done_count - done0, 1);

    // Asynchronous reset at round 30 of an open message
    accept_block(1'b1, 1'b0);
    n = 0;
    while (!(round_en_o && round_o == 30) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check_val("reach_round30", round_o, 30);
    #2;
    reset_i = 1'b1;
    #1;
    check_val("arst_round", round_o, 0);
    check_val("arst_busy", busy_o, 0);
    check_val("arst_ready", ready_o, 0);
    check_val("arst_round_en", round_en_o, 0);
    load_q.delete();
    digest_q.delete();
    tb_msg_open = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    ff0 = ff_count; done0 = done_count;
    for (int i = 0; i < 80; i++) @(negedge clk_i);
    check_val("arst_no_ff", ff_count - ff0, 0);
    check_val("arst_no_done", done_count - done0, 0);
    check_val("arst_idle_ready", ready_o, 1);

    // First block after reset has first_i = 0: err pulse, init from IV
    ff0 = ff_count; done0 = done_count;
    accept_block(1'b0, 1'b1);
    check_rounds();
    check_done_fast();
    check_val("err_blk_ff_cnt", ff_count - ff0, 1);
    check_val("err_blk_done_cnt", done_count - done0, 1);

    // first_i during an open message restarts it (init_hash, no err)
    accept_block(1'b1, 1'b0);
    check_rounds();
    @(negedge clk_i);
    accept_block(1'b1, 1'b1);
    check_rounds();
    check_done_fast();

    check_val("load_q_empty", load_q.size(), 0);
    check_val("digest_q_empty", digest_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL timeout: sim time limit reached, total=%0d bad=%0d", total_cnt, bad_cnt);
    $fatal(1);
  end

endmodule
